// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS constants, control tokens and bit-count helpers.
package tmds_pkg;

    localparam int CNT_W = 5;

    localparam logic [9:0] TOK_00 = 10'h354;
    localparam logic [9:0] TOK_01 = 10'h0AB;
    localparam logic [9:0] TOK_10 = 10'h154;
    localparam logic [9:0] TOK_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n += 4'(d[i]);
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        return c == 2'b00 ? TOK_00 :
               c == 2'b01 ? TOK_01 :
               c == 2'b10 ? TOK_10 : TOK_11;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: one TMDS lane; input capture, transition minimisation,
// then DC balance with a per-lane running disparity.
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       de_i,
    input  logic [1:0] c_i,
    input  logic [7:0] d_i,
    output logic [9:0] q_o
);

    function automatic logic [8:0] minimise(input logic [7:0] d, input logic use_xnor);
        logic [8:0] q;
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
        q[8] = ~use_xnor;
        return q;
    endfunction

    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    logic                    r_de0, r_de1;
    logic [1:0]              r_c0, r_c1;
    logic [7:0]              r_d0;
    logic [8:0]              r_qm;
    logic [9:0]              r_q;
    logic signed [CNT_W-1:0] r_cnt;

    logic [3:0]              w_n1d, w_n1;
    logic                    w_xnor, w_a, w_b;
    logic [8:0]              w_qm;
    logic signed [CNT_W-1:0] w_bal, w_cnt;
    logic [9:0]              w_q;

    assign w_n1d  = popcount8(r_d0);
    assign w_xnor = (w_n1d > 4'd4) || (w_n1d == 4'd4 && !r_d0[0]);
    assign w_qm   = minimise(r_d0, w_xnor);

    // w_bal is n1 - n0 of the minimised byte, always within -8..8
    assign w_n1  = popcount8(r_qm[7:0]);
    assign w_bal = CNT_W'({w_n1, 1'b0}) - CNT_W'(8);
    assign w_a   = (r_cnt == 0) || (w_bal == 0);
    assign w_b   = (r_cnt > 0 && w_bal > 0) || (r_cnt < 0 && w_bal < 0);

    assign w_q = !r_de1 ? ctrl_token(r_c1) :
                 w_a    ? {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]} :
                 w_b    ? {1'b1, r_qm[8], ~r_qm[7:0]} :
                          {1'b0, r_qm[8], r_qm[7:0]};

    assign w_cnt = !r_de1 ? '0 :
                   w_a    ? (r_qm[8] ? r_cnt + w_bal : r_cnt - w_bal) :
                   w_b    ? r_cnt - w_bal + (r_qm[8] ? TWO : '0) :
                            r_cnt + w_bal - (r_qm[8] ? '0 : TWO);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_de0 <= 1'b0;
            r_c0  <= '0;
            r_d0  <= '0;
            r_de1 <= 1'b0;
            r_c1  <= '0;
            r_qm  <= '0;
            r_cnt <= '0;
            r_q   <= TOK_00;
        end else begin
            r_de0 <= de_i;
            r_c0  <= c_i;
            r_d0  <= d_i;
            r_de1 <= r_de0;
            r_c1  <= r_c0;
            r_qm  <= w_qm;
            r_cnt <= w_cnt;
            r_q   <= w_q;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: three-lane DVI TMDS encoder; syncs ride on the blue lane,
// green and red carry control 00 during blanking.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter bit INVERT_SYNC = 1'b0
) (
    input  logic        rst_i,
    input  logic        clk_i,
    input  logic        vsync_i,
    input  logic        hsync_i,
    input  logic        de_i,
    input  logic [23:0] data_i,
    output logic [9:0]  tmds_b_o,
    output logic [9:0]  tmds_g_o,
    output logic [9:0]  tmds_r_o
);

    logic [1:0] w_ctrl_b;

    assign w_ctrl_b = {vsync_i, hsync_i} ^ {2{INVERT_SYNC}};

    tmds_channel_encoder u_b (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .de_i  (de_i),
        .c_i   (w_ctrl_b),
        .d_i   (data_i[7:0]),
        .q_o   (tmds_b_o)
    );

    tmds_channel_encoder u_g (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .de_i  (de_i),
        .c_i   (2'b00),
        .d_i   (data_i[15:8]),
        .q_o   (tmds_g_o)
    );

    tmds_channel_encoder u_r (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .de_i  (de_i),
        .c_i   (2'b00),
        .d_i   (data_i[23:16]),
        .q_o   (tmds_r_o)
    );

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: scoreboard bench; the driver queues expected symbols per
// sampled pixel, the monitor compares them when they are due two edges later.
module tb_tmds_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b0, hs = 1'b0, de = 1'b0;
    logic [23:0] data = '0;
    logic [9:0]  tb_o, tg_o, tr_o;

    typedef struct {
        int         tgt;
        logic [9:0] b;
        logic [9:0] g;
        logic [9:0] r;
        int         tag;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tagn = 0;
    int   mcnt[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tmds_encoder dut (
        .rst_i    (rst),
        .clk_i    (clk),
        .vsync_i  (vs),
        .hsync_i  (hs),
        .de_i     (de),
        .data_i   (data),
        .tmds_b_o (tb_o),
        .tmds_g_o (tg_o),
        .tmds_r_o (tr_o)
    );

    task automatic chk(input string nm, input int tag, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %h, expected %h (t=%0t)", nm, tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].tgt <= cyc) begin
            e = sbq.pop_front();
            if (e.tgt < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL late #%0d: due cycle %0d, seen at %0d", e.tag, e.tgt, cyc);
            end else begin
                chk("blue", e.tag, tb_o, e.b);
                chk("green", e.tag, tg_o, e.g);
                chk("red", e.tag, tr_o, e.r);
            end
        end
    end

    function automatic logic [9:0] token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [9:0] enc(input logic d, input logic [1:0] c, input logic [7:0] x, input int ch);
        int         ones, n1, n0;
        logic       xn;
        logic [8:0] qm;
        logic [9:0] o;
        if (!d) begin
            mcnt[ch] = 0;
            return token(c);
        end
        ones  = $countones(x);
        xn    = (ones > 4) || (ones == 4 && x[0] == 1'b0);
        qm[0] = x[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ x[i]) : (qm[i-1] ^ x[i]);
        qm[8] = !xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (mcnt[ch] == 0 || n1 == n0) begin
            o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            mcnt[ch] += (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            mcnt[ch] += (qm[8] ? 0 : -2) + n1 - n0;
        end
        return o;
    endfunction

    task automatic drv(input logic d, input logic v, input logic h, input logic [23:0] px,
                       input logic [9:0] eb, input logic [9:0] eg, input logic [9:0] er);
        @(posedge clk);
        #1;
        de   = d;
        vs   = v;
        hs   = h;
        data = px;
        sbq.push_back('{cyc + 3, eb, eg, er, tagn});
        tagn++;
    endtask

    task automatic drvm(input logic d, input logic v, input logic h, input logic [23:0] px);
        logic [9:0] eb, eg, er;
        eb = enc(d, {v, h}, px[7:0], 0);
        eg = enc(d, 2'b00, px[15:8], 1);
        er = enc(d, 2'b00, px[23:16], 2);
        drv(d, v, h, px, eb, eg, er);
    endtask

    initial begin
        logic [9:0] alt;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_b", -1, tb_o, 10'h354);
        chk("reset_g", -1, tg_o, 10'h354);
        chk("reset_r", -1, tr_o, 10'h354);
        rst = 1'b0;

        drv(0, 0, 0, 24'h123456, 10'h354, 10'h354, 10'h354);
        drv(0, 0, 1, 24'hABCDEF, 10'h0AB, 10'h354, 10'h354);
        drv(0, 1, 0, 24'hFFFFFF, 10'h154, 10'h354, 10'h354);
        drv(0, 1, 1, 24'h000000, 10'h2AB, 10'h354, 10'h354);
        drv(0, 0, 0, 24'h5A5A5A, 10'h354, 10'h354, 10'h354);

        // zero pixels from cnt=0: disparity walks -8,2,-6,4,-4,6,-2,8
        for (int i = 0; i < 8; i++) begin
            alt = (i % 2 == 0) ? 10'h100 : 10'h3FF;
            drv(1, 0, 0, 24'h000000, alt, alt, alt);
        end
        drv(0, 0, 0, 24'hFFFFFF, 10'h354, 10'h354, 10'h354);
        for (int i = 0; i < 5; i++) begin
            alt = (i % 2 == 0) ? 10'h100 : 10'h3FF;
            drv(1, 0, 0, 24'h000000, alt, alt, alt);
        end
        drv(0, 0, 0, 24'h000000, 10'h354, 10'h354, 10'h354);
        drv(1, 0, 0, 24'h00FF00, 10'h100, 10'h200, 10'h100);
        drv(0, 0, 1, 24'h000000, 10'h0AB, 10'h354, 10'h354);
        drv(0, 0, 0, 24'h000000, 10'h354, 10'h354, 10'h354);

        drv(1, 0, 0, 24'h000000, 10'h100, 10'h100, 10'h100);
        drv(1, 0, 0, 24'h000000, 10'h3FF, 10'h3FF, 10'h3FF);
        drv(1, 0, 0, 24'h000000, 10'h100, 10'h100, 10'h100);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("async_rst_b", -2, tb_o, 10'h354);
        chk("async_rst_g", -2, tg_o, 10'h354);
        chk("async_rst_r", -2, tr_o, 10'h354);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        de   = 1'b1;
        vs   = 1'b0;
        hs   = 1'b0;
        data = 24'h000000;
        sbq.push_back('{cyc + 1, 10'h354, 10'h354, 10'h354, tagn++});
        sbq.push_back('{cyc + 2, 10'h354, 10'h354, 10'h354, tagn++});
        sbq.push_back('{cyc + 3, 10'h100, 10'h100, 10'h100, tagn++});
        drv(1, 0, 0, 24'h000000, 10'h3FF, 10'h3FF, 10'h3FF);
        drv(1, 0, 0, 24'h000000, 10'h100, 10'h100, 10'h100);
        drv(0, 0, 0, 24'h000000, 10'h354, 10'h354, 10'h354);

        for (int ln = 0; ln < 3; ln++) begin
            int bl;
            bl = int'($urandom_range(1, 40));
            for (int i = 0; i < bl; i++)
                drvm(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom()));
            for (int i = 0; i < 640; i++)
                drvm(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom()));
        end
        drvm(0, 0, 0, 24'h000000);
        drvm(0, 1, 1, 24'h000000);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected symbols never came due", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Three-channel DVI-mode TMDS 8b/10b encoder placed directly downstream of the video timing/pixel generator. It consumes per-pixel vsync/hsync/de/24-bit RGB and produces one 10-bit symbol per channel per pixel clock, for the serializer that drives the HDMI TMDS lanes. It implements transition minimisation, DC balance through per-channel running disparity, and control-token insertion during blanking. Data islands and guard bands are out of scope.

## Interface
- `INVERT_SYNC`, default 0: when 1, hsync_i/vsync_i are inverted before control encoding.
- `rst_i` input 1: reset, asynchronous, active-high.
- `clk_i` input 1: pixel clock.
- `vsync_i` input 1: vertical sync, one pixel per cycle.
- `hsync_i` input 1: horizontal sync.
- `de_i` input 1: data enable; 1 = active pixel.
- `data_i` input 24: pixel, R=[23:16], G=[15:8], B=[7:0]; valid only when de_i=1.
- `tmds_b_o` output 10: channel 0 symbol; carries the sync controls. Bit 0 is transmitted first.
- `tmds_g_o` output 10: channel 1 symbol; control bits are 00.
- `tmds_r_o` output 10: channel 2 symbol; control bits are 00.

## Operation
**Control mapping**
- Blue channel uses C1C0 = {vsync, hsync}, after optional inversion.
- Green and red channels use C1C0 = 00.

**Stage 1 (transition minimisation), per channel**
- N1(D) = number of ones in the 8-bit data.
- Use XNOR if N1>4, or if N1==4 and D[0]==0; otherwise use XOR.
- q_m[0] = D[0].
- q_m[i] = q_m[i-1] op D[i], for i = 1..7.
- q_m[8] = 1 for XOR, 0 for XNOR.
- de and C1C0 are registered alongside q_m.

**Stage 2 (DC balance)**
- cnt is a signed 5-bit running disparity per channel.
- n1 / n0 = number of ones / zeros in q_m[7:0].
- q_out[8] = q_m[8] in every data branch.
- Branch A, taken if cnt==0 or n1==n0:
  - q_out[9] = ~q_m[8].
  - q_out[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0].
  - cnt += q_m[8] ? (n1-n0) : (n0-n1).
- Branch B, taken if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
  - q_out[9] = 1, q_out[7:0] = ~q_m[7:0].
  - cnt += 2·q_m[8] + (n0-n1).
- Branch C, otherwise:
  - q_out[9] = 0, q_out[7:0] = q_m[7:0].
  - cnt += −2·(~q_m[8]) + (n1-n0).

**Blanking (stage-2 de = 0)**
- Symbol is the control token:
  - 00 → 0x354
  - 01 → 0x0AB
  - 10 → 0x154
  - 11 → 0x2AB
- cnt is cleared to 0.

**Reset**
- All pipeline de bits = 0, C1C0 = 00, cnt = 0.
- All three outputs = 0x354.
- Reset asserted mid-line abandons in-flight pixels. The first cycle after release outputs 0x354.

## Timing
- Latency is fixed at 2 cycles: inputs sampled at edge n appear on the outputs after edge n+2.
- Syncs and data share the same latency, so sync/de alignment is preserved exactly.
- Throughput is one symbol per channel per clock. There is no backpressure.
- A de 1→0 transition switches to tokens on the same pipeline cycle; the disparity cleared in that cycle applies to the next active pixel.
- A de 0→1 transition encodes the first pixel with cnt = 0.
- data_i is don't-care when de_i = 0 and must not affect cnt.
- |cnt| never exceeds 8 with the rules above; 5-bit signed is sufficient, and no wrap is permitted.

## Structure
- Package `tmds_pkg` holds:
  - The four control-token constants.
  - A popcount-of-8 function.
  - The cnt width constant (5).
- One sub-module, `tmds_channel_encoder`, implements the 2-stage pipeline and disparity for one channel. It has ports clk_i, rst_i, de_i, c_i[1:0], d_i[7:0], q_o[9:0].
- `tmds_encoder` instantiates `tmds_channel_encoder` three times and contains the sync inversion and control mapping.

## Test plan
- Reset released, de=0, hsync=vsync=0 → all outputs 0x354 from reset onward.
- Blanking with {vsync,hsync} = 01, 10, 11 → blue shows 0x0AB / 0x154 / 0x2AB two cycles later; green and red stay 0x354.
- de=1, B=0x00 held for 8 pixels from cnt=0 → blue alternates 0x100, 0x3FF, 0x100, 0x3FF…, with cnt sequence −8, 2, −6, 4, −4, 6, −2, 8.
- de=1, G=0xFF, first pixel after blanking → green = 0x200 (XNOR path, branch A).
- Active line ending with cnt≠0, one blanking cycle, then the same pixel stream → identical symbols to the first line (disparity cleared).
- rst_i pulsed mid-active-line → outputs 0x354 asynchronously. After release, with de=1 and B=0x00, the first blue symbol is 0x100.
- Golden-model comparison over random frames: 640 active pixels per line, random RGB, randomised blanking lengths.
